truth_table_sweeper: RTL
========================

TRUTH_TABLE_SWEEPER -- requirements
Module: truth_table_sweeper

Interface
REQ-001 Parameter SETTLE_CYCLES, default 4, cycles the circuit inputs are held before the output is sampled (legal range 1..255).
REQ-002 Parameter EXPECTED_TT, default 8'hC2, expected 3-input truth-table word for the circuit under evaluation.
REQ-003 Port clk, input, 1 bit, single clock; all state changes occur on the rising edge.
REQ-004 Port rst_n, input, 1 bit, asynchronous active-low reset.
REQ-005 Port start, input, 1 bit, single-cycle request to begin a sweep.
REQ-006 Ports in1, in2, in3, outputs, 1 bit each, registered drive to the circuit under evaluation.
REQ-007 Port out, input, 1 bit, circuit output being captured.
REQ-008 Port busy, output, 1 bit, high while a sweep is in progress.
REQ-009 Port done, output, 1 bit, single-cycle pulse when a sweep completes.
REQ-010 Port tt_word, output, 8 bits, captured truth table, held stable until the next sweep completes.
REQ-011 Port match, output, 1 bit, high when tt_word equals EXPECTED_TT; valid from the done cycle onward.
REQ-012 Port glitch, output, 1 bit, high when any instability was detected (present only with SWEEPER_GLITCH_CHECK_EN).

Function
REQ-013 The FSM SHALL have the states IDLE, DRIVE, SETTLE, SAMPLE and FINISH.
REQ-014 IDLE to DRIVE SHALL occur on start=1; start SHALL be ignored in every other state.
REQ-015 DRIVE SHALL load {in1,in2,in3} = idx[2:0] (in1 = MSB), clear the settle counter, then go to SETTLE.
REQ-016 SETTLE SHALL count SETTLE_CYCLES cycles, then go to SAMPLE.
REQ-017 SAMPLE SHALL write out into shadow bit [7-idx]; for idx=7 the next state SHALL be FINISH, otherwise idx increments and the next state SHALL be DRIVE.
REQ-018 FINISH SHALL copy the shadow register to tt_word, update match, pulse done for one cycle, clear idx to 0, drive in1..in3 to 0 and return to IDLE.
REQ-019 One sweep SHALL take exactly 8*(SETTLE_CYCLES+2)+1 cycles from the first busy cycle to done inclusive; busy SHALL be high from the cycle after start up to and including the FINISH cycle.
REQ-020 A start in the same cycle as the done pulse SHALL be ignored; start is accepted only in IDLE.
REQ-021 The 3-bit idx SHALL not wrap mid-sweep, and tt_word SHALL not change between done pulses.

Reset
REQ-022 Asserting rst_n low at any time, including mid-sweep, SHALL immediately force IDLE and set idx=0, the counter to 0, in1..in3=0, busy=0, done=0, tt_word=0, match=0 and glitch=0; the partial sweep SHALL be discarded.

Configuration
REQ-023 With SWEEPER_GLITCH_CHECK_EN defined, out SHALL be compared against its previous-cycle value during every SETTLE cycle after the first; any difference SHALL set a sticky flag that is cleared in DRIVE for idx=0 and copied to glitch in FINISH; match SHALL then also require glitch=0.
REQ-024 Without SWEEPER_GLITCH_CHECK_EN, the glitch port and its logic SHALL be absent, and match SHALL depend only on tt_word.

Structure
REQ-025 A shared package sweeper_pkg SHALL hold the state enum typedef, the 3-bit index typedef, and the constants TT_WIDTH=8 and NUM_INPUTS=3.
REQ-026 A single sub-module, settle_counter (load, enable, terminal-count output), SHALL implement the SETTLE timer.

Verification
REQ-027 Behavioural 0xC2 function connected, SETTLE_CYCLES=4, one start pulse -> done after 49 cycles, tt_word=8'hC2, match=1.
REQ-028 Constant out=1 -> tt_word=8'hFF, match=0; a second sweep with the correct circuit -> tt_word=8'hC2, match=1.
REQ-029 start pulsed repeatedly while busy, and again on the done cycle -> exactly one done pulse and no extra sweep.
REQ-030 rst_n low during SETTLE for idx=3 -> all outputs 0 on the next edge; a fresh start -> full 49-cycle sweep with the correct result.
REQ-031 SWEEPER_GLITCH_CHECK_EN defined, out toggled once in the settle window for idx=5 -> glitch=1 and match=0 even with tt_word=8'hC2.
REQ-032 Input sequencing check -> {in1,in2,in3} steps 000..111 in order, each value held SETTLE_CYCLES+2 cycles.

Source files
------------

// File: rtl/sweeper_pkg.sv
// Shared types and constants for the truth-table sweeper.
// Optional feature macro used by the sweeper: SWEEPER_GLITCH_CHECK_EN.
package sweeper_pkg;

    localparam int TT_WIDTH   = 8;
    localparam int NUM_INPUTS = 3;

    typedef enum logic [2:0] {
        IDLE,
        DRIVE,
        SETTLE,
        SAMPLE,
        FINISH
    } state_e;

    typedef logic [NUM_INPUTS-1:0] idx_t;

endpackage

// File: rtl/truth_table_sweeper_settle_counter.sv
// Settle timer: cleared by load, counts while enabled, and flags the last
// cycle of a SETTLE_CYCLES-long window.
module settle_counter #(
    parameter int unsigned SETTLE_CYCLES = 4
) (
    input  logic clk,
    input  logic rst_n,
    input  logic load,
    input  logic enable,
    output logic tc
);

    localparam logic [7:0] LAST = 8'(SETTLE_CYCLES - 1);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (load) begin
            cnt_d = '0;
        end else if (enable) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign tc = enable && (cnt_q == LAST);

endmodule

// File: rtl/truth_table_sweeper.sv
// Drives all 8 input combinations into a 3-input circuit and captures its truth table.
// Define SWEEPER_GLITCH_CHECK_EN to add output-stability checking during settle.
module truth_table_sweeper
    import sweeper_pkg::*;
#(
    parameter int unsigned          SETTLE_CYCLES = 4,
    parameter logic [TT_WIDTH-1:0]  EXPECTED_TT   = 8'hC2
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                start,
    output logic                in1,
    output logic                in2,
    output logic                in3,
    input  logic                out,
    output logic                busy,
    output logic                done,
    output logic [TT_WIDTH-1:0] tt_word,
`ifdef SWEEPER_GLITCH_CHECK_EN
    output logic                glitch,
`endif
    output logic                match
);

    localparam idx_t IDX_LAST = '1;

    state_e              state_q, state_d;
    idx_t                idx_q, idx_d;
    idx_t                drive_q, drive_d;
    logic [TT_WIDTH-1:0] shadow_q, shadow_d;
    logic [TT_WIDTH-1:0] tt_q, tt_d;
    logic                match_q, match_d;
    logic                cnt_load;
    logic                cnt_en;
    logic                cnt_tc;
`ifdef SWEEPER_GLITCH_CHECK_EN
    logic                sticky_q, sticky_d;
    logic                glitch_q, glitch_d;
    logic                out_prev_q, out_prev_d;
    logic                settle_prev_q, settle_prev_d;
`endif

    settle_counter #(
        .SETTLE_CYCLES(SETTLE_CYCLES)
    ) u_settle_counter (
        .clk    (clk),
        .rst_n  (rst_n),
        .load   (cnt_load),
        .enable (cnt_en),
        .tc     (cnt_tc)
    );

    always_comb begin
        state_d  = state_q;
        idx_d    = idx_q;
        drive_d  = drive_q;
        shadow_d = shadow_q;
        tt_d     = tt_q;
        match_d  = match_q;
        cnt_load = 1'b0;
        cnt_en   = 1'b0;
`ifdef SWEEPER_GLITCH_CHECK_EN
        sticky_d      = sticky_q;
        glitch_d      = glitch_q;
        out_prev_d    = out;
        settle_prev_d = (state_q == SETTLE);
`endif
        case (state_q)
            IDLE: begin
                if (start) begin
                    state_d = DRIVE;
                end
            end
            DRIVE: begin
                drive_d  = idx_q;
                cnt_load = 1'b1;
`ifdef SWEEPER_GLITCH_CHECK_EN
                if (idx_q == '0) begin
                    sticky_d = 1'b0;
                end
`endif
                state_d = SETTLE;
            end
            SETTLE: begin
                cnt_en = 1'b1;
`ifdef SWEEPER_GLITCH_CHECK_EN
                // The first settle cycle follows an input change, so it is not compared.
                if (settle_prev_q && (out != out_prev_q)) begin
                    sticky_d = 1'b1;
                end
`endif
                if (cnt_tc) begin
                    state_d = SAMPLE;
                end
            end
            SAMPLE: begin
                shadow_d[IDX_LAST - idx_q] = out;
                // Results are published on entry to FINISH so they are valid with done.
                if (idx_q == IDX_LAST) begin
                    tt_d = shadow_d;
`ifdef SWEEPER_GLITCH_CHECK_EN
                    glitch_d = sticky_q;
                    match_d  = (shadow_d == EXPECTED_TT) && !sticky_q;
`else
                    match_d  = (shadow_d == EXPECTED_TT);
`endif
                    state_d = FINISH;
                end else begin
                    idx_d   = idx_q + 1'b1;
                    state_d = DRIVE;
                end
            end
            FINISH: begin
                idx_d   = '0;
                drive_d = '0;
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            idx_q    <= '0;
            drive_q  <= '0;
            shadow_q <= '0;
            tt_q     <= '0;
            match_q  <= 1'b0;
`ifdef SWEEPER_GLITCH_CHECK_EN
            sticky_q      <= 1'b0;
            glitch_q      <= 1'b0;
            out_prev_q    <= 1'b0;
            settle_prev_q <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            idx_q    <= idx_d;
            drive_q  <= drive_d;
            shadow_q <= shadow_d;
            tt_q     <= tt_d;
            match_q  <= match_d;
`ifdef SWEEPER_GLITCH_CHECK_EN
            sticky_q      <= sticky_d;
            glitch_q      <= glitch_d;
            out_prev_q    <= out_prev_d;
            settle_prev_q <= settle_prev_d;
`endif
        end
    end

    assign {in1, in2, in3} = drive_q;
    assign busy            = (state_q != IDLE);
    assign done            = (state_q == FINISH);
    assign tt_word         = tt_q;
    assign match           = match_q;
`ifdef SWEEPER_GLITCH_CHECK_EN
    assign glitch          = glitch_q;
`endif

endmodule
